// File: rtl/conv_window_ctrl_if.sv
// Handshake bundle for conv_window_ctrl: pixel stream in, 3x3 window and
// start/done to the convolution unit, result stream out.
interface conv_window_ctrl_if;
   localparam int unsigned PIX_W = 8;
   localparam int unsigned WIN_W = 9 * PIX_W;
   localparam int unsigned RES_W = 24;

   logic             pix_valid;
   logic [PIX_W-1:0] pix_in;
   logic             pix_ready;
   logic [WIN_W-1:0] f_win;
   logic             conv_start;
   logic             conv_done;
   logic [RES_W-1:0] conv_result;
   logic             out_valid;
   logic [RES_W-1:0] out_data;
   logic             out_ready;
   logic             frame_done;
   logic             err;

   modport slave (
      input  pix_valid, pix_in, conv_done, conv_result, out_ready,
      output pix_ready, f_win, conv_start, out_valid, out_data, frame_done, err
   );

   modport master (
      output pix_valid, pix_in, conv_done, conv_result, out_ready,
      input  pix_ready, f_win, conv_start, out_valid, out_data, frame_done, err
   );
endinterface

// File: rtl/conv_window_ctrl.sv
// Raster-to-3x3 window controller: builds windows from two line buffers and
// hands each complete window to a convolution unit. Optional watchdog: CONV_TIMEOUT_EN.
module conv_window_ctrl #(
   parameter int unsigned IMG_W = 8,
   parameter int unsigned IMG_H = 8
) (
   input  logic               clk,
   input  logic               reset,
   conv_window_ctrl_if.slave  bus
);
   localparam int unsigned PIX_W = 8;
   localparam int unsigned WIN_W = 9 * PIX_W;
   localparam int unsigned RES_W = 24;
   localparam int unsigned COL_W = $clog2(IMG_W);
   localparam int unsigned ROW_W = $clog2(IMG_H);

   typedef enum logic [1:0] {S_IDLE, S_CONV, S_OUT} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [COL_W-1:0] r_col;
   logic [ROW_W-1:0] r_row;
   logic [PIX_W-1:0] r_lb0 [IMG_W];
   logic [PIX_W-1:0] r_lb1 [IMG_W];
   logic [WIN_W-1:0] r_win;
   logic             r_pix_ready;
   logic             r_conv_start;
   logic             r_out_valid;
   logic [RES_W-1:0] r_out_data;
   logic             r_frame_done;
   logic             w_accept;
   logic             w_col_last;
   logic             w_row_last;
   logic             w_complete;
   logic             w_load_out;
`ifdef CONV_TIMEOUT_EN
   logic [3:0]       r_wdog;
   logic             r_err;
   logic             w_timeout;
`endif

   // Next-state and per-cycle strobes
   always_comb begin
      w_state_nxt = r_state;
      w_load_out  = 1'b0;
      w_accept    = bus.pix_valid && r_pix_ready;
      w_col_last  = (r_col == COL_W'(IMG_W - 1));
      w_row_last  = (r_row == ROW_W'(IMG_H - 1));
      w_complete  = w_accept && (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));
`ifdef CONV_TIMEOUT_EN
      w_timeout   = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            if (w_complete) w_state_nxt = S_CONV;
         end
         S_CONV: begin
            if (bus.conv_done) begin
               w_load_out  = 1'b1;
               w_state_nxt = S_OUT;
            end
`ifdef CONV_TIMEOUT_EN
            else if (r_wdog == 4'hF) begin
               w_timeout   = 1'b1;
               w_state_nxt = S_IDLE;
            end
`endif
         end
         S_OUT: begin
            if (bus.out_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Registered handshakes, counters and window; the window shifts left so column 1 is oldest
   always_ff @(posedge clk) begin
      if (reset) begin
         r_col        <= '0;
         r_row        <= '0;
         r_win        <= '0;
         r_pix_ready  <= 1'b0;
         r_conv_start <= 1'b0;
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_pix_ready  <= (w_state_nxt == S_IDLE);
         r_conv_start <= (w_state_nxt == S_CONV);
         r_out_valid  <= (w_state_nxt == S_OUT);
         r_frame_done <= w_accept && w_col_last && w_row_last;
         if (w_load_out) r_out_data <= bus.conv_result;
         if (w_accept) begin
            r_win <= {r_win[63:48], r_lb1[r_col],
                      r_win[39:24], r_lb0[r_col],
                      r_win[15:0],  bus.pix_in};
            if (w_col_last) begin
               r_col <= '0;
               r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
            end else begin
               r_col <= r_col + COL_W'(1);
            end
         end
      end
   end

   // lb0 holds the previous row, lb1 the row before it, indexed by column
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < IMG_W; i++) begin
            r_lb0[i] <= '0;
            r_lb1[i] <= '0;
         end
      end else if (w_accept) begin
         r_lb1[r_col] <= r_lb0[r_col];
         r_lb0[r_col] <= bus.pix_in;
      end
   end

`ifdef CONV_TIMEOUT_EN
   // Counts cycles spent in CONV; 16 cycles without done abandons the window
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wdog <= '0;
         r_err  <= 1'b0;
      end else begin
         if ((r_state == S_CONV) && (w_state_nxt == S_CONV)) r_wdog <= r_wdog + 4'd1;
         else                                                r_wdog <= '0;
         if (w_timeout) r_err <= 1'b1;
      end
   end
   assign bus.err = r_err;
`else
   assign bus.err = 1'b0;
`endif

   assign bus.pix_ready  = r_pix_ready;
   assign bus.f_win      = r_win;
   assign bus.conv_start = r_conv_start;
   assign bus.out_valid  = r_out_valid;
   assign bus.out_data   = r_out_data;
   assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_conv_window_ctrl.sv
// Scoreboard bench for conv_window_ctrl on a 4x4 frame of pixels 1..16.
module tb_conv_window_ctrl;
   localparam int unsigned W = 4;
   localparam int unsigned H = 4;
   localparam logic [71:0] WINS [4] = '{72'h01_02_03_05_06_07_09_0A_0B,
                                        72'h02_03_04_06_07_08_0A_0B_0C,
                                        72'h05_06_07_09_0A_0B_0D_0E_0F,
                                        72'h06_07_08_0A_0B_0C_0E_0F_10};
   localparam logic [23:0] SUMS [4] = '{24'd54, 24'd63, 24'd90, 24'd99};

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   conv_window_ctrl_if bus ();
   conv_window_ctrl #(.IMG_W(W), .IMG_H(H)) dut (.clk(clk), .reset(reset), .bus(bus));

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [71:0] exp_win [$];
   logic [23:0] exp_data [$];
   int          done_dly   = 2;
   int          model_mode = 1;
   int          exp_len    = -1;
   int          fd_cnt     = 0;
   int          start_len  = 0;
   logic        start_q    = 1'b0;
   logic [71:0] cur_win    = '0;

   task automatic check(input string nm, input logic [71:0] act, input logic [71:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic fail_now(input string nm);
      n_checks++;
      n_fail++;
      $display("FAIL %s (bound expired or unexpected event)", nm);
   endtask

   function automatic logic [23:0] win_sum(input logic [71:0] w);
      logic [23:0] s = '0;
      for (int i = 0; i < 9; i++) s += 24'(w[i*8 +: 8]);
      return s;
   endfunction

   // Convolution unit model: sums the window, done_dly cycles after start
   initial begin
      bit active = 1'b0;
      int k = 0;
      bus.conv_done   = 1'b0;
      bus.conv_result = '0;
      forever begin
         @(posedge clk); #1;
         bus.conv_done = (model_mode == 1);
         if (model_mode == 1) bus.conv_result = 24'hABCDEF;
         if (model_mode == 0) begin
            if (!bus.conv_start)  active = 1'b0;
            else if (!active) begin active = 1'b1; k = 0; end
            else k++;
            if (active && k == done_dly) begin
               bus.conv_done   = 1'b1;
               bus.conv_result = win_sum(bus.f_win);
               active          = 1'b0;
            end
         end else begin
            active = 1'b0;
         end
      end
   end

   // Monitor: pops expected results and windows as the DUT presents them
   always @(negedge clk) begin
      if (bus.out_valid && bus.out_ready) begin
         if (exp_data.size() == 0) fail_now("out_unexpected");
         else check("out_data", 72'(bus.out_data), 72'(exp_data.pop_front()));
      end
      if (bus.conv_start && !start_q) begin
         start_len = 0;
         if (exp_win.size() == 0) fail_now("start_unexpected");
         else cur_win = exp_win.pop_front();
      end
      if (bus.conv_start) begin
         check("f_win", bus.f_win, cur_win);
         start_len++;
      end else if (start_q && exp_len >= 0) begin
         check("start_len", 72'(start_len), 72'(exp_len));
      end
      start_q = bus.conv_start;
      if (bus.frame_done) fd_cnt++;
   end

   task automatic send_pixel(input logic [7:0] v);
      logic acc = 1'b0;
      bus.pix_valid = 1'b1;
      bus.pix_in    = v;
      for (int n = 0; n < 300 && !acc; n++) begin
         @(negedge clk); acc = bus.pix_ready;
         @(posedge clk); #1;
      end
      bus.pix_valid = 1'b0;
      if (!acc) fail_now("pix_accept_timeout");
   endtask

   task automatic send_frame(input int npix);
      for (int p = 1; p <= npix; p++) send_pixel(8'(p));
   endtask

   task automatic push_frame_exp();
      for (int i = 0; i < 4; i++) begin
         exp_win.push_back(WINS[i]);
         exp_data.push_back(SUMS[i]);
      end
   endtask

   task automatic wait_drain();
      for (int n = 0; n < 300 && exp_data.size() != 0; n++) begin
         @(posedge clk); #1;
      end
      if (exp_data.size() != 0) fail_now("drain_timeout");
      repeat (2) begin @(posedge clk); #1; end
   endtask

   task automatic run_frame(input int dly, input int len, input string nm);
      int fd0;
      done_dly = dly;
      exp_len  = len;
      push_frame_exp();
      fd0 = fd_cnt;
      send_frame(16);
      wait_drain();
      check({nm, "_frame_done"}, 72'(fd_cnt - fd0), 72'd1);
      check({nm, "_err"}, 72'(bus.err), 72'd0);
   endtask

   initial begin
      int fd0;
      reset         = 1'b1;
      bus.pix_valid = 1'b1;
      bus.pix_in    = 8'hFF;
      bus.out_ready = 1'b1;

      // Reset with every input active
      @(posedge clk); @(negedge clk);
      check("rst_pix_ready",  72'(bus.pix_ready),  72'd0);
      check("rst_conv_start", 72'(bus.conv_start), 72'd0);
      check("rst_out_valid",  72'(bus.out_valid),  72'd0);
      check("rst_out_data",   72'(bus.out_data),   72'd0);
      check("rst_frame_done", 72'(bus.frame_done), 72'd0);
      check("rst_err",        72'(bus.err),        72'd0);
      check("rst_f_win",      bus.f_win,           72'd0);
      @(posedge clk); #1;
      reset         = 1'b0;
      bus.pix_valid = 1'b0;
      model_mode    = 0;
      @(negedge clk);
      check("rst_held_out_valid", 72'(bus.out_valid), 72'd0);
      @(posedge clk); @(negedge clk);
      check("rel_pix_ready", 72'(bus.pix_ready), 72'd1);
      @(posedge clk); #1;

      run_frame(2, 3, "frame1");

      // Backpressure on the first result
      done_dly      = 2;
      exp_len       = 3;
      bus.out_ready = 1'b0;
      push_frame_exp();
      fd0 = fd_cnt;
      fork
         send_frame(16);
      join_none
      for (int n = 0; n < 100 && !bus.out_valid; n++) begin
         @(posedge clk); #1;
      end
      if (!bus.out_valid) fail_now("bp_out_valid_timeout");
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("bp_out_valid", 72'(bus.out_valid), 72'd1);
         check("bp_out_data",  72'(bus.out_data),  72'd54);
         check("bp_pix_ready", 72'(bus.pix_ready), 72'd0);
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      wait fork;
      wait_drain();
      check("bp_frame_done", 72'(fd_cnt - fd0), 72'd1);

      run_frame(8, 9, "slow");

      // Reset while waiting on a slow convolution
      done_dly = 8;
      exp_len  = -1;
      exp_win.push_back(WINS[0]);
      send_frame(11);
      repeat (3) begin @(posedge clk); #1; end
      check("mid_conv_start_before", 72'(bus.conv_start), 72'd1);
      reset = 1'b1;
      @(posedge clk); @(negedge clk);
      check("mid_conv_start", 72'(bus.conv_start), 72'd0);
      check("mid_out_valid",  72'(bus.out_valid),  72'd0);
      check("mid_f_win",      bus.f_win,           72'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      run_frame(2, 3, "after_rst");

`ifdef CONV_TIMEOUT_EN
      // Convolution unit never answers
      model_mode = 2;
      exp_len    = 16;
      exp_win.push_back(WINS[0]);
      send_frame(11);
      for (int n = 0; n < 40 && !bus.err; n++) @(negedge clk);
      check("to_err",        72'(bus.err),        72'd1);
      check("to_pix_ready",  72'(bus.pix_ready),  72'd1);
      check("to_conv_start", 72'(bus.conv_start), 72'd0);
      check("to_out_valid",  72'(bus.out_valid),  72'd0);
      @(posedge clk); #1;
`endif

      repeat (2) begin @(posedge clk); #1; end
      check("exp_data_left", 72'(exp_data.size()), 72'd0);
      check("exp_win_left",  72'(exp_win.size()),  72'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/conv_window_ctrl.md
CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 8, meaning image width in pixels (at least 3).
REQ-002 SHALL have parameter IMG_H, default 8, meaning image height in rows (at least 3).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port pix_valid, input, 1 bit: raster pixel offered.
REQ-006 SHALL have port pix_in, input, 8 bits: pixel value, unsigned.
REQ-007 SHALL have port pix_ready, output, 1 bit: pixel accepted when pix_valid and pix_ready are both high.
REQ-008 SHALL have port f_win, output, 72 bits: 3x3 window; f11 in [71:64], f12 in [63:56], ... f33 in [7:0].
REQ-009 SHALL have port conv_start, output, 1 bit: start request to the convolution unit.
REQ-010 SHALL have port conv_done, input, 1 bit: convolution unit result valid.
REQ-011 SHALL have port conv_result, input, 24 bits: convolution sum.
REQ-012 SHALL have port out_valid, output, 1 bit: result available.
REQ-013 SHALL have port out_data, output, 24 bits: captured result.
REQ-014 SHALL have port out_ready, input, 1 bit: downstream accepts out_data.
REQ-015 SHALL have port frame_done, output, 1 bit: one-cycle pulse after the last pixel of a frame.
REQ-016 SHALL have port err, output, 1 bit: sticky timeout flag (see Configuration).

Function
REQ-017 SHALL implement states IDLE, CONV and OUT; pix_ready = 1 only in IDLE.
REQ-018 SHALL keep column and row counters; on each accepted pixel, col increments, and at IMG_W-1 col wraps to 0 and row increments; at the last pixel row wraps to 0.
REQ-019 SHALL keep two line buffers of IMG_W pixels and a 3x3 window register, shifted only on accepted pixels.
REQ-020 SHALL place the newest pixel at f33, the previous row at f2x, the row before that at f1x, with column 1 as the oldest column.
REQ-021 SHALL treat a window as complete when an accepted pixel has row>=2 and col>=2 (no padding), giving (IMG_W-2)*(IMG_H-2) results per frame.
REQ-022 SHALL move IDLE->CONV on the edge that accepts a completing pixel; otherwise it stays in IDLE.
REQ-023 In CONV, SHALL hold conv_start=1 and f_win stable until conv_done is sampled high.
REQ-024 SHALL, on conv_done=1 in CONV, load out_data from conv_result, go to OUT, and drive conv_start=0 from the next cycle.
REQ-025 In OUT, SHALL hold out_valid=1 and out_data stable; on out_ready=1 it SHALL go to IDLE and clear out_valid at that edge.
REQ-026 SHALL keep conv_start low for at least one cycle between two starts.
REQ-027 SHALL pulse frame_done for the cycle after the last pixel of the frame is accepted; the counters SHALL be zero by then.
REQ-028 SHALL ignore conv_done and conv_result outside CONV.

Reset
REQ-029 On reset=1 at a clock edge, state SHALL become IDLE; col, row, line buffers and window SHALL become 0; conv_start, out_valid, out_data, frame_done and err SHALL become 0. This holds mid-CONV and mid-OUT; any pending result is discarded.
REQ-030 pix_ready SHALL be 1 from the first edge after reset is released.

Configuration
REQ-031 With macro CONV_TIMEOUT_EN defined, a 4-bit watchdog SHALL count cycles in CONV; if conv_done is not seen within 16 cycles, the block SHALL set err=1 (sticky until reset), drop conv_start, skip that result and return to IDLE.
REQ-032 Without CONV_TIMEOUT_EN, CONV SHALL wait indefinitely and err SHALL be tied to 0.

Verification
REQ-033 Reset: assert reset for 2 cycles with all inputs active -> all outputs 0; pix_ready=1 on the next cycle.
REQ-034 Frame: IMG_W=IMG_H=4, pixels 1..16, conv model = sum of the window, done two cycles after start -> out_data 54, 63, 90, 99 in order; first f_win = 1,2,3,5,6,7,9,10,11; frame_done pulses once.
REQ-035 Backpressure: out_ready held 0 for 10 cycles -> out_valid=1, out_data unchanged, pix_ready=0 throughout.
REQ-036 Slow done: conv_done delayed 8 cycles -> conv_start held 1, f_win stable, exactly one result captured.
REQ-037 Reset mid-CONV -> conv_start=0 after the edge; a following full frame yields the correct 4 results.
REQ-038 With CONV_TIMEOUT_EN and conv_done held 0 -> err=1 after 16 CONV cycles; state IDLE; pix_ready=1.
